fp_accumulator: RTL and testbench

- Downstream consumer of the 13-bit-to-floating-point converter output (S, E[2:0], F[4:0]; value = (-1)^S * F * 2^E).
- Accepts one converted sample per valid/ready handshake and re-expands it to linear magnitude with a multi-cycle shifter.
- Adds each sample into a saturating signed accumulator, then presents the sum after NUM_SAMPLES samples via an output handshake.

---
 rtl/fp_accumulator.sv | 164 ++++++++++++++++
 tb/tb_fp_accumulator.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_accumulator.sv
// -----------------------------------------------------------------------------
// fp_accumulator
//
// Takes compact floating-point samples (sign, 3-bit exponent, 5-bit
// significand; value = (-1)^S * F * 2^E), turns each one back into a linear
// magnitude with a shift-one-bit-per-cycle shifter, and adds it into a
// saturating two's-complement accumulator. After NUM_SAMPLES samples the block
// sum is presented on a valid/ready output handshake and held until it is
// accepted.
//
// Parameters
//   NUM_SAMPLES  samples per accumulation block (1..15)
//   ACC_W        accumulator / sum width in bits (13..24)
//
// Ports
//   clk        system clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset; any partial block is discarded
//   in_valid   upstream sample valid
//   in_ready   high only in IDLE: a sample is accepted on in_valid && in_ready
//   s_in       sample sign (1 = negative)
//   e_in       sample exponent; the sample keeps the block busy for E+1 cycles
//   f_in       sample significand
//   out_valid  high only in DONE: sum and sat are final and held
//   out_ready  downstream accepts the sum; ignored outside DONE
//   sum        the accumulator register (meaningful while out_valid=1)
//   sat        sticky: the current block clamped at least once
// -----------------------------------------------------------------------------
module fp_accumulator #(
  parameter int NUM_SAMPLES = 4,
  parameter int ACC_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             s_in,
  input  logic [2:0]       e_in,
  input  logic [4:0]       f_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sum,
  output logic             sat
);

  // Elaboration-time guard on the legal parameter ranges.
  if (NUM_SAMPLES < 1 || NUM_SAMPLES > 15) begin : g_bad_num_samples
    $error("fp_accumulator: NUM_SAMPLES must be in 1..15");
  end
  if (ACC_W < 13 || ACC_W > 24) begin : g_bad_acc_w
    $error("fp_accumulator: ACC_W must be in 13..24");
  end

  localparam int MAG_W = 13;  // 31 << 7 = 3968 fits in 13 bits

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ACCUM,
    DONE
  } state_t;

  state_t             state;
  logic               sign;
  logic [MAG_W-1:0]   mag;
  logic [2:0]         shift_cnt;
  logic [3:0]         sample_cnt;
  logic [ACC_W-1:0]   acc;

  // ---------------------------------------------------------------------------
  // Saturating add/subtract, evaluated every cycle but only committed in ACCUM.
  // One guard bit is enough: |mag| < 2^12 <= 2^(ACC_W-1), so a single add can
  // overshoot the ACC_W range by less than a full range. Overflow shows up as
  // the guard bit disagreeing with the ACC_W-1 sign bit.
  // ---------------------------------------------------------------------------
  logic [ACC_W:0]   acc_ext;
  logic [ACC_W:0]   mag_ext;
  logic [ACC_W:0]   sum_ext;
  logic             ovf;
  logic [ACC_W-1:0] acc_next;
  logic [3:0]       cnt_inc;
  logic             block_last;

  // NOTE: every signal assigned in this always_comb gets a value on every path
  // (defaults first), so no latch can be inferred.
  always_comb begin
    acc_ext    = {acc[ACC_W-1], acc};
    mag_ext    = {{(ACC_W + 1 - MAG_W){1'b0}}, mag};
    sum_ext    = sign ? (acc_ext - mag_ext) : (acc_ext + mag_ext);
    ovf        = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    acc_next   = sum_ext[ACC_W-1:0];
    if (ovf) begin
      // Guard bit holds the true sign of the unclamped result.
      acc_next = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                : {1'b0, {(ACC_W-1){1'b1}}};
    end
    cnt_inc    = sample_cnt + 4'd1;
    block_last = (cnt_inc == 4'(NUM_SAMPLES));
  end

  // ---------------------------------------------------------------------------
  // Control FSM and datapath registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sign       <= 1'b0;
      mag        <= '0;
      shift_cnt  <= '0;
      sample_cnt <= '0;
      acc        <= '0;
      sat        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign      <= s_in;
            mag       <= {{(MAG_W - 5){1'b0}}, f_in};
            shift_cnt <= e_in;
            state     <= (e_in == 3'd0) ? ACCUM : SHIFT;
          end
        end

        SHIFT: begin
          // One bit per cycle: exactly E cycles spent here.
          mag       <= mag << 1;
          shift_cnt <= shift_cnt - 3'd1;
          if (shift_cnt == 3'd1) begin
            state <= ACCUM;
          end
        end

        ACCUM: begin
          // A negative zero (S=1, F=0) lands here too: it adds nothing but
          // still counts toward the block.
          acc        <= acc_next;
          sat        <= sat | ovf;
          sample_cnt <= cnt_inc;
          state      <= block_last ? DONE : IDLE;
        end

        DONE: begin
          // Sum and sat hold until the downstream side takes them.
          if (out_ready) begin
            acc        <= '0;
            sample_cnt <= '0;
            sat        <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs are pure decodes of the state register, so no input
  // reaches an output without first passing through a flop.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = acc;

endmodule

// File: tb/tb_fp_accumulator.sv
// -----------------------------------------------------------------------------
// tb_fp_accumulator
//
// Two instances: dut (NUM_SAMPLES=4, ACC_W=16) for the nominal, reset, latency,
// backpressure and back-to-back scenarios, and dut_sat (NUM_SAMPLES=2,
// ACC_W=13) for positive and negative saturation. Expected block results are
// pushed into a per-instance queue when the block is issued; a monitor per
// instance pops and compares whenever out_valid && out_ready is seen.
// -----------------------------------------------------------------------------
module tb_fp_accumulator;

  typedef struct packed {
    logic [15:0] sum;
    logic        sat;
  } exp16_t;

  typedef struct packed {
    logic [12:0] sum;
    logic        sat;
  } exp13_t;

  logic        clk;
  logic        rst_n;

  // Main instance signals.
  logic        in_valid;
  logic        in_ready;
  logic        s_in;
  logic [2:0]  e_in;
  logic [4:0]  f_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        sat;

  // Saturation instance signals.
  logic        t_in_valid;
  logic        t_in_ready;
  logic        t_s_in;
  logic [2:0]  t_e_in;
  logic [4:0]  t_f_in;
  logic        t_out_valid;
  logic        t_out_ready;
  logic [12:0] t_sum;
  logic        t_sat;

  int n_checks;
  int n_fail;

  exp16_t q16[$];
  exp13_t q13[$];

  fp_accumulator #(.NUM_SAMPLES(4), .ACC_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .s_in     (s_in),
    .e_in     (e_in),
    .f_in     (f_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .sat      (sat)
  );

  fp_accumulator #(.NUM_SAMPLES(2), .ACC_W(13)) dut_sat (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (t_in_valid),
    .in_ready (t_in_ready),
    .s_in     (t_s_in),
    .e_in     (t_e_in),
    .f_in     (t_f_in),
    .out_valid(t_out_valid),
    .out_ready(t_out_ready),
    .sum      (t_sum),
    .sat      (t_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors: compare a finished block whenever the output handshake fires.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q16.size() == 0) begin
        check("main_unexpected_output", 32'(sum), 32'hDEAD);
      end else begin
        exp16_t e;
        e = q16.pop_front();
        check("main_sum", 32'(sum), 32'(e.sum));
        check("main_sat", 32'(sat), 32'(e.sat));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && t_out_valid && t_out_ready) begin
      if (q13.size() == 0) begin
        check("sat_unexpected_output", 32'(t_sum), 32'hDEAD);
      end else begin
        exp13_t e;
        e = q13.pop_front();
        check("satdut_sum", 32'(t_sum), 32'(e.sum));
        check("satdut_sat", 32'(t_sat), 32'(e.sat));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Offer one sample to the main instance once in_ready is seen; returns 1 ns
  // after the accept edge.
  task automatic send(input logic s, input logic [2:0] e, input logic [4:0] f);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("main_in_ready_timeout", 32'(in_ready), 32'd1);
    s_in     = s;
    e_in     = e;
    f_in     = f;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_t(input logic s, input logic [2:0] e, input logic [4:0] f);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!t_in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!t_in_ready) check("sat_in_ready_timeout", 32'(t_in_ready), 32'd1);
    t_s_in     = s;
    t_e_in     = e;
    t_f_in     = f;
    t_in_valid = 1'b1;
    @(posedge clk);
    #1 t_in_valid = 1'b0;
  endtask

  // Count how many negedges in_ready stays low after an accept.
  task automatic busy_cycles(output int n);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_out_valid(input string name);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!out_valid) check(name, 32'(out_valid), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic main_sequence();
    int n;
    logic [2:0] btb_e [4];
    logic [4:0] btb_f [4];
    logic       btb_s [4];
    int waited;

    // Nominal block: 208 - 80 + 5 - 3968 = -3835 = 16'hF105.
    q16.push_back('{sum: 16'hF105, sat: 1'b0});
    send(1'b0, 3'd3, 5'd26);
    send(1'b1, 3'd2, 5'd20);
    send(1'b0, 3'd0, 5'd5);
    send(1'b1, 3'd7, 5'd31);

    // Latency: E=7 keeps in_ready low 8 cycles, E=0 keeps it low 1 cycle.
    send(1'b0, 3'd7, 5'd31);
    busy_cycles(n);
    check("latency_e7", 32'(n), 32'd8);
    send(1'b0, 3'd0, 5'd1);
    busy_cycles(n);
    check("latency_e0", 32'(n), 32'd1);

    // Finish that block under backpressure: 3968 + 1 + 2 - 6 = 3965.
    q16.push_back('{sum: 16'd3965, sat: 1'b0});
    out_ready = 1'b0;
    send(1'b0, 3'd0, 5'd2);
    send(1'b1, 3'd1, 5'd3);
    wait_out_valid("bp_out_valid_timeout");
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_sum_held", 32'(sum), 32'd3965);
      check("bp_sat_held", 32'(sat), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      s_in     = 1'b0;
      e_in     = 3'd3;
      f_in     = 5'd7;
      in_valid = (k % 2 == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_sum", 32'(sum), 32'd0);
    check("bp_release_sat", 32'(sat), 32'd0);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // Back-to-back with in_valid held high; negative zero counts as a sample.
    // 0 + 2 + 0 + 12 = 14.
    btb_s = '{1'b1, 1'b0, 1'b0, 1'b0};
    btb_e = '{3'd4, 3'd1, 3'd0, 3'd2};
    btb_f = '{5'd0, 5'd1, 5'd0, 5'd3};
    q16.push_back('{sum: 16'd14, sat: 1'b0});
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_in = btb_s[i];
      e_in = btb_e[i];
      f_in = btb_f[i];
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) check("btb_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic sat_sequence();
    // 3968 + 3968 = 7936 > 4095: clamps to 4095.
    q13.push_back('{sum: 13'd4095, sat: 1'b1});
    send_t(1'b0, 3'd7, 5'd31);
    send_t(1'b0, 3'd7, 5'd31);
    // -3968 - 3968 < -4096: clamps to -4096.
    q13.push_back('{sum: 13'h1000, sat: 1'b1});
    send_t(1'b1, 3'd7, 5'd31);
    send_t(1'b1, 3'd7, 5'd31);
  endtask

  initial begin
    int waited;
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    s_in        = 1'b0;
    e_in        = 3'd0;
    f_in        = 5'd0;
    out_ready   = 1'b1;
    t_in_valid  = 1'b0;
    t_s_in      = 1'b0;
    t_e_in      = 3'd0;
    t_f_in      = 5'd0;
    t_out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_sum", 32'(sum), 32'd0);
    check("reset_sat", 32'(sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-SHIFT discards a partial block (acc=5 before the reset).
    send(1'b0, 3'd0, 5'd5);
    send(1'b0, 3'd7, 5'd31);
    @(posedge clk);
    @(posedge clk);
    #2;
    check("pre_reset_busy", 32'(in_ready), 32'd0);
    check("pre_reset_acc", 32'(sum), 32'd5);
    rst_n = 1'b0;
    #1;
    check("midshift_rst_sum", 32'(sum), 32'd0);
    check("midshift_rst_in_ready", 32'(in_ready), 32'd1);
    check("midshift_rst_out_valid", 32'(out_valid), 32'd0);
    check("midshift_rst_sat", 32'(sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fork
      main_sequence();
      sat_sequence();
    join

    waited = 0;
    while ((q16.size() != 0 || q13.size() != 0) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    check("main_queue_drained", 32'(q16.size()), 32'd0);
    check("sat_queue_drained", 32'(q13.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
